// File: rtl/cnn_pkg.sv
// Shared constants and arithmetic helpers for the CNN pixel pipeline stages.
package cnn_pkg;

  localparam int PSUM_W = 8;
  localparam int ACC_W  = 12;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clamp a signed value into the signed range of a w-bit word.
  function automatic int sat_signed(input int v, input int w);
    int hi;
    int lo;
    hi = (1 << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

endpackage

// File: rtl/psum_fifo2.sv
// Two-entry synchronous FIFO with a registered head word, shared by pipeline stages.
module psum_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] tail;
  logic [1:0]   count;
  logic         do_pop;
  logic         do_push;

  // A push into a full queue is only taken when the head leaves the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (do_push) begin
            head  <= push_data;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (do_push && do_pop) begin
            head <= push_data;
          end else if (do_push) begin
            tail  <= push_data;
            count <= 2'd2;
          end else if (do_pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          if (do_push && do_pop) begin
            head <= tail;
            tail <= push_data;
          end else if (do_pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/psum_acc.sv
// Accumulates TERMS row partial sums into one saturated pixel, buffered in a 2-deep queue.
// Define PSUM_ACC_RELU_EN to clamp negative pixels to zero before they are queued.
module psum_acc #(
  parameter int WIDTH = cnn_pkg::PSUM_W,
  parameter int TERMS = 3,
  parameter int ACC_W = cnn_pkg::ACC_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 in_psum,
  input  logic                             in_vld,
  input  logic                             in_clear,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic                             err_ovf,
  output logic [cnn_pkg::clog2(TERMS):0]   term_cnt
);

  import cnn_pkg::*;

  localparam int CNT_W = clog2(TERMS) + 1;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic                    last_term;
  logic [WIDTH-1:0]        push_val;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop;

  assign sum       = acc + {{(ACC_W - WIDTH){in_psum[WIDTH-1]}}, in_psum};
  assign last_term = in_vld && !in_clear && (term_cnt == CNT_W'(TERMS - 1));
  assign out_vld   = !fifo_empty;
  assign pop       = out_vld && out_rdy;

`ifdef PSUM_ACC_RELU_EN
  assign push_val = WIDTH'(relu(sat_signed(32'(sum), WIDTH)));
`else
  assign push_val = WIDTH'(sat_signed(32'(sum), WIDTH));
`endif

  // Clear has priority over a valid term, so a last term arriving with clear is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      term_cnt <= '0;
    end else if (in_clear) begin
      acc      <= '0;
      term_cnt <= '0;
    end else if (in_vld) begin
      if (last_term) begin
        acc      <= '0;
        term_cnt <= '0;
      end else begin
        acc      <= sum;
        term_cnt <= term_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
    end else if (last_term && fifo_full && !pop) begin
      err_ovf <= 1'b1;
    end
  end

  psum_fifo2 #(
    .W(WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (last_term),
    .push_data(push_val),
    .pop      (pop),
    .head     (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
